mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: cpu_clk cycles allowed in WAIT before a phase is aborted (range 2..255).
REQ-002 cpu_clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_rst  in  1  memory controller initialising; no phase is issued while high.
REQ-005 c_req  in  1  CPU request; sampled only in IDLE.
REQ-006 c_addr  in  20  byte address; c_wdata  in  16  write data; c_we  in  1  1=write; c_byte  in  1  1=byte access.
REQ-007 c_ack  out  1  one-cycle completion pulse; c_err  out  1  valid with c_ack, 1=aborted; c_rdata  out  16  read result, valid with c_ack.
REQ-008 m_addr  out  20; m_wr_data  out  16; m_we  out  1  active-low write strobe; m_byte_m  out  1  byte mode.
REQ-009 m_rd_data  in  16  memory read data; m_ready  in  1  memory idle/phase complete.

Function
REQ-010 States: IDLE, ISSUE, WAIT, ISSUE2, WAIT2, DONE; transitions only on cpu_clk rising edge.
REQ-011 IDLE -> ISSUE when c_req=1 and mem_rst=0; request fields latched on that edge; c_req ignored outside IDLE.
REQ-012 ISSUE lasts exactly one cycle: drives m_addr, m_byte_m, m_wr_data, and m_we=0 for writes / 1 for reads, then -> WAIT.
REQ-013 m_* outputs held stable from ISSUE until the phase ends; m_ready is ignored in the ISSUE cycle.
REQ-014 WAIT ends on first edge with m_ready=1; read data captured from m_rd_data on that edge.
REQ-015 Byte read result: c_rdata = {8'h00, m_rd_data[7:0]}; word read: c_rdata = m_rd_data; writes: c_rdata = 16'h0000.
REQ-016 DONE lasts one cycle: c_ack=1, c_err=0, m_we=1, then -> IDLE; minimum request-to-ack latency 3 cycles (single phase, m_ready already high).
REQ-017 Timeout: 8-bit counter cleared on entering WAIT/WAIT2; when it reaches TIMEOUT with m_ready=0 -> DONE with c_err=1, c_rdata=0, second phase skipped.
REQ-018 mem_rst=1 while in ISSUE/WAIT/ISSUE2/WAIT2 -> DONE with c_err=1 on the next edge.
REQ-019 Outside ISSUE/WAIT/ISSUE2/WAIT2, m_we=1 and m_byte_m=0; m_addr and m_wr_data hold last value.

Reset
REQ-020 rst=1 immediately forces state IDLE, c_ack=0, c_err=0, c_rdata=0, m_addr=0, m_wr_data=0, m_we=1, m_byte_m=0, timeout counter=0, including mid-operation; no ack for the aborted request.

Configuration
REQ-021 Macro MEM_MASTER_SPLIT_ODD_EN defined: word request with c_addr[0]=1 runs two byte phases: phase 1 at c_addr with low byte, phase 2 (ISSUE2/WAIT2) at c_addr+1 (modulo 2^20, 20'hFFFFF -> 20'h00000) with high byte; read result = {phase-2 byte, phase-1 byte}; single c_ack after phase 2.
REQ-022 Split write phases drive m_wr_data = {8'h00, byte}.
REQ-023 Macro undefined: ISSUE2/WAIT2 unreachable; odd word requests run as one word phase passed through unchanged.

Structure
REQ-024 Shared package holds state encoding typedef, address width (20), data width (16) and default TIMEOUT constant.
REQ-025 One sub-module natural: mem_master_tmo (loadable counter with expiry flag), instantiated once and reused across both phases.

Verification
REQ-026 Word write 20'h00004/16'h4321, m_ready high after 2 cycles -> one phase, m_we low during ISSUE/WAIT, c_ack with c_err=0.
REQ-027 Byte read 20'h00005, m_rd_data=16'hAB65 -> c_rdata=16'h0065, m_byte_m=1.
REQ-028 With MEM_MASTER_SPLIT_ODD_EN, word read 20'h007FF returning 8'h21 then 8'h43 -> phases at 20'h007FF and 20'h00800, c_rdata=16'h4321; at 20'hFFFFF second phase at 20'h00000.
REQ-029 Without the macro, same 20'h007FF word read -> single word phase, c_rdata=m_rd_data.
REQ-030 m_ready held 0, TIMEOUT=8 -> c_ack with c_err=1, c_rdata=0 eight cycles after entering WAIT; m_we returns to 1.
REQ-031 rst pulsed mid-WAIT and mem_rst raised mid-WAIT -> immediate idle outputs, no ack; and DONE with c_err=1, respectively; c_req held during mem_rst=1 -> no ISSUE until mem_rst=0.

Source files
------------

// File: rtl/mem_master_pkg.sv
// Shared definitions for the mem_master CPU-to-memory bridge.
// Optional feature macro: MEM_MASTER_SPLIT_ODD_EN (see mem_master.sv).
package mem_master_pkg;

    localparam int ADDR_W      = 20;
    localparam int DATA_W      = 16;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/mem_master_if.sv
// CPU request/response and memory-controller bus bundle for mem_master.
interface mem_master_if;
    import mem_master_pkg::*;

    // CPU side
    logic              c_req;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_we;
    logic              c_byte;
    logic              c_ack;
    logic              c_err;
    logic [DATA_W-1:0] c_rdata;

    // Memory-controller side
    logic              mem_rst;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wr_data;
    logic              m_we;
    logic              m_byte_m;
    logic [DATA_W-1:0] m_rd_data;
    logic              m_ready;

    modport master (
        input  c_req, c_addr, c_wdata, c_we, c_byte,
        output c_ack, c_err, c_rdata,
        input  mem_rst, m_rd_data, m_ready,
        output m_addr, m_wr_data, m_we, m_byte_m
    );

    modport slave (
        output c_req, c_addr, c_wdata, c_we, c_byte,
        input  c_ack, c_err, c_rdata,
        output mem_rst, m_rd_data, m_ready,
        input  m_addr, m_wr_data, m_we, m_byte_m
    );

endinterface

// File: rtl/mem_master_tmo.sv
// WAIT-phase timeout counter: cleared while not waiting, counts waiting
// cycles and flags the last cycle allowed before the phase is aborted.
module mem_master_tmo #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    // Expiry on the cycle whose closing edge would make the count reach LIMIT
    assign expired_o = (cnt_q == 8'(LIMIT - 1));

    // Clear has priority; saturate once expired
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + 8'd1;
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_master.sv
// mem_master: turns single CPU requests into memory-controller phases with
// timeout and memory-reset abort. With MEM_MASTER_SPLIT_ODD_EN defined, an
// odd-addressed word access is split into two byte phases (ISSUE2/WAIT2).
module mem_master
    import mem_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         cpu_clk,
    input  logic         rst,
    mem_master_if.master bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        hi_q, hi_d;      // high write byte kept for phase 2
    logic [7:0]        lo_q, lo_d;      // low read byte from phase 1
    logic              we_q, we_d;
    logic              byte_q, byte_d;
    logic              split_q, split_d;
    logic              err_q, err_d;
    logic              abort;
    logic              tmo_clr, tmo_en, tmo_exp;
    logic              split_req;
    logic              active;

`ifdef MEM_MASTER_SPLIT_ODD_EN
    assign split_req = !bus.c_byte && bus.c_addr[0];
`else
    assign split_req = 1'b0;
`endif

    mem_master_tmo #(.LIMIT(TIMEOUT)) u_tmo (
        .clk_i     (cpu_clk),
        .rst_i     (rst),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_exp)
    );

    // Next-state, request latching, phase sequencing and abort handling
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        we_d    = we_q;
        byte_d  = byte_q;
        split_d = split_q;
        err_d   = err_q;
        abort   = 1'b0;
        tmo_clr = 1'b1;
        tmo_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.c_req && !bus.mem_rst) begin
                    state_d = ISSUE;
                    addr_d  = bus.c_addr;
                    wdata_d = split_req ? {8'h00, bus.c_wdata[7:0]} : bus.c_wdata;
                    hi_d    = bus.c_wdata[15:8];
                    we_d    = bus.c_we;
                    byte_d  = bus.c_byte;
                    split_d = split_req;
                    err_d   = 1'b0;
                end
            end
            ISSUE, ISSUE2: begin
                if (bus.mem_rst)
                    abort = 1'b1;
                else
                    state_d = (state_q == ISSUE) ? WAIT : WAIT2;
            end
            WAIT: begin
                tmo_clr = 1'b0;
                tmo_en  = 1'b1;
                if (bus.mem_rst) begin
                    abort = 1'b1;
                end else if (bus.m_ready) begin
                    if (split_q) begin
                        state_d = ISSUE2;
                        addr_d  = addr_q + 20'd1;
                        wdata_d = {8'h00, hi_q};
                        lo_d    = bus.m_rd_data[7:0];
                    end else begin
                        state_d = DONE;
                        if (we_q)
                            rdata_d = '0;
                        else if (byte_q)
                            rdata_d = {8'h00, bus.m_rd_data[7:0]};
                        else
                            rdata_d = bus.m_rd_data;
                    end
                end else if (tmo_exp) begin
                    abort = 1'b1;
                end
            end
            WAIT2: begin
                tmo_clr = 1'b0;
                tmo_en  = 1'b1;
                if (bus.mem_rst) begin
                    abort = 1'b1;
                end else if (bus.m_ready) begin
                    state_d = DONE;
                    rdata_d = we_q ? '0 : {bus.m_rd_data[7:0], lo_q};
                end else if (tmo_exp) begin
                    abort = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            split_q <= split_d;
            err_q   <= err_d;
        end
    end

    // Strobes are only asserted while a phase is in flight; address/data hold
    assign active        = (state_q == ISSUE) || (state_q == WAIT) ||
                           (state_q == ISSUE2) || (state_q == WAIT2);
    assign bus.m_addr    = addr_q;
    assign bus.m_wr_data = wdata_q;
    assign bus.m_we      = !(active && we_q);
    assign bus.m_byte_m  = active && (byte_q || split_q);
    assign bus.c_ack     = (state_q == DONE);
    assign bus.c_err     = (state_q == DONE) && err_q;
    assign bus.c_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: directed cases plus randomized requests
// checked against a transaction-level model of the expected phases/results.
module tb_mem_master;

    localparam int TMO = 8;
`ifdef MEM_MASTER_SPLIT_ODD_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic cpu_clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    mem_master_if bus();

    mem_master #(.TIMEOUT(TMO)) dut (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    // One request end to end. w0/w1: WAIT cycles until m_ready per phase
    // (values above TMO mean the memory never answers); d0/d1: read data.
    task automatic run_txn(input logic [19:0] a, input logic [15:0] wd, input logic we,
                           input logic byt, input int w0, input int w1,
                           input logic [15:0] d0, input logic [15:0] d1);
        logic        split, err;
        int          nph, w;
        logic [19:0] pa [2];
        logic [15:0] pw [2];
        logic [15:0] exp_rd, d;
        logic [19:0] last_a;

        split  = SPLIT && !byt && a[0];
        nph    = split ? 2 : 1;
        pa[0]  = a;
        pa[1]  = a + 20'd1;
        pw[0]  = split ? {8'h00, wd[7:0]} : wd;
        pw[1]  = {8'h00, wd[15:8]};
        err    = (w0 > TMO) || (split && (w1 > TMO));
        last_a = (split && (w0 <= TMO)) ? pa[1] : pa[0];
        if (err || we)     exp_rd = 16'h0000;
        else if (split)    exp_rd = {d1[7:0], d0[7:0]};
        else if (byt)      exp_rd = {8'h00, d0[7:0]};
        else               exp_rd = d0;

        bus.c_req   = 1'b1;
        bus.c_addr  = a;
        bus.c_wdata = wd;
        bus.c_we    = we;
        bus.c_byte  = byt;
        @(negedge cpu_clk);
        // Request fields are latched; scramble them to prove it
        bus.c_req   = 1'b0;
        bus.c_addr  = 20'($urandom);
        bus.c_wdata = 16'($urandom);
        bus.c_we    = 1'($urandom);
        bus.c_byte  = 1'($urandom);

        for (int p = 0; p < nph; p++) begin
            w = (p == 0) ? w0 : w1;
            d = (p == 0) ? d0 : d1;
            chk("issue_addr", bus.m_addr, pa[p]);
            chk("issue_we", bus.m_we, !we);
            chk("issue_byte", bus.m_byte_m, byt || split);
            if (we) chk("issue_wdata", bus.m_wr_data, pw[p]);
            bus.m_ready   = 1'($urandom);   // must be ignored during ISSUE
            bus.m_rd_data = 16'($urandom);
            for (int i = 1; i <= TMO; i++) begin
                @(negedge cpu_clk);
                chk("wait_addr", bus.m_addr, pa[p]);
                chk("wait_we", bus.m_we, !we);
                chk("wait_noack", bus.c_ack, 1'b0);
                bus.m_ready   = (i == w);
                bus.m_rd_data = (i == w) ? d : 16'($urandom);
                if (i == w) break;
            end
            @(negedge cpu_clk);
            bus.m_ready = 1'b0;
            if (w > TMO) break;
        end

        chk("done_ack", bus.c_ack, 1'b1);
        chk("done_err", bus.c_err, err);
        chk("done_rdata", bus.c_rdata, exp_rd);
        chk("done_we", bus.m_we, 1'b1);
        chk("done_byte", bus.m_byte_m, 1'b0);
        @(negedge cpu_clk);
        chk("ack_pulse", bus.c_ack, 1'b0);
        chk("hold_addr", bus.m_addr, last_a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int w0, w1;

        rst           = 1'b1;
        bus.c_req     = 1'b0;
        bus.c_addr    = '0;
        bus.c_wdata   = '0;
        bus.c_we      = 1'b0;
        bus.c_byte    = 1'b0;
        bus.mem_rst   = 1'b0;
        bus.m_rd_data = '0;
        bus.m_ready   = 1'b0;
        @(negedge cpu_clk);
        chk("rst_ack", bus.c_ack, 1'b0);
        chk("rst_err", bus.c_err, 1'b0);
        chk("rst_rdata", bus.c_rdata, 16'h0000);
        chk("rst_maddr", bus.m_addr, 20'h00000);
        chk("rst_mwdata", bus.m_wr_data, 16'h0000);
        chk("rst_mwe", bus.m_we, 1'b1);
        chk("rst_mbyte", bus.m_byte_m, 1'b0);
        rst = 1'b0;
        @(negedge cpu_clk);

        // Directed cases
        run_txn(20'h00004, 16'h4321, 1'b1, 1'b0, 2, 1, 16'h0000, 16'h0000);
        run_txn(20'h00005, 16'h0000, 1'b0, 1'b1, 1, 1, 16'hAB65, 16'h0000);
        run_txn(20'h007FF, 16'h0000, 1'b0, 1'b0, 1, 3, 16'h5521, 16'h6643);
        run_txn(20'hFFFFF, 16'h0000, 1'b0, 1'b0, 2, 2, 16'h7721, 16'h8843);
        run_txn(20'h007FF, 16'hA1B2, 1'b1, 1'b0, 1, 2, 16'h0000, 16'h0000);
        run_txn(20'h00010, 16'h0000, 1'b0, 1'b0, 20, 1, 16'h1234, 16'h0000);
        run_txn(20'h00012, 16'h9999, 1'b1, 1'b0, 20, 1, 16'h0000, 16'h0000);
        run_txn(20'h00014, 16'h0000, 1'b0, 1'b0, TMO, 1, 16'hCAFE, 16'h0000);
        run_txn(20'h00016, 16'h0000, 1'b0, 1'b0, TMO + 1, 1, 16'hCAFE, 16'h0000);
        run_txn(20'h00021, 16'h0000, 1'b0, 1'b0, 2, 20, 16'h1111, 16'h2222);

        // Asynchronous reset in the middle of a write WAIT
        bus.c_req = 1'b1; bus.c_addr = 20'h12345; bus.c_wdata = 16'hBEEF;
        bus.c_we = 1'b1; bus.c_byte = 1'b0;
        @(negedge cpu_clk);
        bus.c_req = 1'b0;
        @(negedge cpu_clk);
        chk("rstmid_pre_we", bus.m_we, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_we", bus.m_we, 1'b1);
        chk("rstmid_byte", bus.m_byte_m, 1'b0);
        chk("rstmid_addr", bus.m_addr, 20'h00000);
        chk("rstmid_wdata", bus.m_wr_data, 16'h0000);
        chk("rstmid_ack", bus.c_ack, 1'b0);
        chk("rstmid_rdata", bus.c_rdata, 16'h0000);
        @(negedge cpu_clk);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) begin
            @(negedge cpu_clk);
            chk("rstmid_noack", bus.c_ack, 1'b0);
        end
        bus.m_ready = 1'b0;

        // Memory reset in the middle of a read WAIT, then request held off
        bus.c_req = 1'b1; bus.c_addr = 20'h00100; bus.c_we = 1'b0; bus.c_byte = 1'b0;
        @(negedge cpu_clk);
        bus.c_req = 1'b0;
        bus.m_rd_data = 16'h5A5A;
        @(negedge cpu_clk);
        bus.mem_rst = 1'b1;
        @(negedge cpu_clk);
        chk("mrst_ack", bus.c_ack, 1'b1);
        chk("mrst_err", bus.c_err, 1'b1);
        chk("mrst_rdata", bus.c_rdata, 16'h0000);
        chk("mrst_we", bus.m_we, 1'b1);
        bus.c_req = 1'b1; bus.c_addr = 20'h00200; bus.c_wdata = 16'h0F0F; bus.c_we = 1'b1;
        repeat (3) begin
            @(negedge cpu_clk);
            chk("mrst_hold_we", bus.m_we, 1'b1);
            chk("mrst_hold_ack", bus.c_ack, 1'b0);
        end
        bus.mem_rst = 1'b0;
        @(negedge cpu_clk);
        chk("mrst_issue_we", bus.m_we, 1'b0);
        chk("mrst_issue_addr", bus.m_addr, 20'h00200);
        bus.c_req = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        chk("mrst_after_ack", bus.c_ack, 1'b1);
        chk("mrst_after_err", bus.c_err, 1'b0);
        bus.m_ready = 1'b0;
        @(negedge cpu_clk);

        // Randomized requests
        for (int n = 0; n < 60; n++) begin
            logic [19:0] a;
            a = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom);
            case ($urandom_range(0, 9))
                0:       w0 = TMO;
                1:       w0 = TMO + 1 + int'($urandom_range(0, 3));
                default: w0 = int'($urandom_range(1, 4));
            endcase
            case ($urandom_range(0, 9))
                0:       w1 = TMO + 2;
                default: w1 = int'($urandom_range(1, 4));
            endcase
            run_txn(a, 16'($urandom), 1'($urandom), 1'($urandom), w0, w1,
                    16'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
